// File: rtl/vx_mshr_pkg.sv
// Shared types for the vx_mshr_pf miss reservation table: per-entry state
// encoding and the width of the performance counters.
package vx_mshr_pkg;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_READY   = 2'd2,
        ST_DRAIN   = 2'd3
    } mshr_state_e;

    localparam int PERF_W = 32;

endpackage

// File: rtl/vx_mshr_pf_sel.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest set bit (0 when none).
module vx_mshr_pf_sel #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        valid = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/vx_mshr_pf.sv
// Cache-bank MSHR with prefetch tracking, fill merging and ordered replay.
// Define VX_MSHR_PERF_EN to build the saturating late-prefetch/alloc-stall counters.
module vx_mshr_pf
    import vx_mshr_pkg::*;
#(
    parameter int MSHR_SIZE       = 8,
    parameter int NUM_LOOKUPS     = 2,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = $clog2(MSHR_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   allocate_valid,
    input  logic [LINE_ADDR_WIDTH-1:0]             allocate_addr,
    input  logic [DATA_WIDTH-1:0]                  allocate_data,
    input  logic                                   allocate_prefetch,
    output logic                                   allocate_ready,
    output logic [ID_WIDTH-1:0]                    allocate_id,
    input  logic [NUM_LOOKUPS-1:0]                 lookup_valid,
    input  logic [NUM_LOOKUPS*LINE_ADDR_WIDTH-1:0] lookup_addr,
    output logic [NUM_LOOKUPS-1:0]                 lookup_match,
    output logic [NUM_LOOKUPS-1:0]                 lookup_late_prefetch,
    input  logic                                   fill_valid,
    input  logic [ID_WIDTH-1:0]                    fill_id,
    output logic [LINE_ADDR_WIDTH-1:0]             fill_addr,
    output logic                                   dequeue_valid,
    output logic [ID_WIDTH-1:0]                    dequeue_id,
    output logic [LINE_ADDR_WIDTH-1:0]             dequeue_addr,
    output logic [DATA_WIDTH-1:0]                  dequeue_data,
    output logic                                   dequeue_prefetch,
    input  logic                                   dequeue_ready,
    input  logic                                   release_valid,
    input  logic [ID_WIDTH-1:0]                    release_id,
    output logic [31:0]                            perf_late_pf,
    output logic [31:0]                            perf_alloc_stall
);

    mshr_state_e                st_q [MSHR_SIZE];
    mshr_state_e                st_n [MSHR_SIZE];
    logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_SIZE];
    logic [DATA_WIDTH-1:0]      data_q [MSHR_SIZE];
    logic [MSHR_SIZE-1:0]       pf_q, pf_n;
    logic [MSHR_SIZE-1:0]       free_n, ready_n;
    logic [MSHR_SIZE-1:0]       hit [NUM_LOOKUPS];

    logic                       alloc_fire, deq_fire, deq_hold;
    logic                       free_any, rdy_any;
    logic [ID_WIDTH-1:0]        free_idx, rdy_idx;

    assign alloc_fire = allocate_valid && allocate_ready;
    assign deq_fire   = dequeue_valid && dequeue_ready;
    assign fill_addr  = addr_q[fill_id];

    always_comb begin
        lookup_match         = '0;
        lookup_late_prefetch = '0;
        for (int p = 0; p < NUM_LOOKUPS; p++) begin
            hit[p] = '0;
            for (int i = 0; i < MSHR_SIZE; i++) begin
                hit[p][i] = (st_q[i] != ST_FREE) &&
                            (addr_q[i] == lookup_addr[p*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH]);
            end
            lookup_match[p]         = |hit[p];
            lookup_late_prefetch[p] = |(hit[p] & pf_q);
        end
    end

    // Next-state: later updates win, so release overrides promotion and fill.
    always_comb begin
        st_n = st_q;
        pf_n = pf_q;
        for (int p = 0; p < NUM_LOOKUPS; p++) begin
            if (lookup_valid[p]) pf_n = pf_n & ~hit[p];
        end
        if (alloc_fire) begin
            st_n[allocate_id] = ST_PENDING;
            pf_n[allocate_id] = allocate_prefetch;
        end
        if (fill_valid) begin
            for (int i = 0; i < MSHR_SIZE; i++) begin
                if ((ID_WIDTH'(i) == fill_id) ||
                    (st_q[i] == ST_PENDING && addr_q[i] == fill_addr))
                    st_n[i] = ST_READY;
            end
        end
        if (deq_fire) st_n[dequeue_id] = ST_DRAIN;
        if (release_valid) begin
            st_n[release_id] = ST_FREE;
            pf_n[release_id] = 1'b0;
        end
        for (int i = 0; i < MSHR_SIZE; i++) begin
            free_n[i]  = (st_n[i] == ST_FREE);
            ready_n[i] = (st_n[i] == ST_READY);
        end
    end

    // Hold the presented candidate only while it is still a legal READY entry.
    assign deq_hold = dequeue_valid && !dequeue_ready && (st_n[dequeue_id] == ST_READY);

    vx_mshr_pf_sel #(.N(MSHR_SIZE), .IDX_W(ID_WIDTH)) u_free_sel (
        .req   (free_n),
        .valid (free_any),
        .index (free_idx)
    );

    vx_mshr_pf_sel #(.N(MSHR_SIZE), .IDX_W(ID_WIDTH)) u_ready_sel (
        .req   (ready_n),
        .valid (rdy_any),
        .index (rdy_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSHR_SIZE; i++) st_q[i] <= ST_FREE;
            pf_q           <= '0;
            allocate_ready <= 1'b0;
            allocate_id    <= '0;
            dequeue_valid  <= 1'b0;
            dequeue_id     <= '0;
        end else begin
            st_q           <= st_n;
            pf_q           <= pf_n;
            allocate_ready <= free_any;
            allocate_id    <= free_idx;
            if (!deq_hold) begin
                dequeue_valid <= rdy_any;
                dequeue_id    <= rdy_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            addr_q[allocate_id] <= allocate_addr;
            data_q[allocate_id] <= allocate_data;
        end
        if (!deq_hold) begin
            dequeue_addr     <= addr_q[rdy_idx];
            dequeue_data     <= data_q[rdy_idx];
            dequeue_prefetch <= pf_n[rdy_idx];
        end
    end

`ifdef VX_MSHR_PERF_EN
    logic [PERF_W-1:0] late_cnt_q, stall_cnt_q, late_inc;

    function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                  input logic [PERF_W-1:0] b);
        logic [PERF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PERF_W] ? {PERF_W{1'b1}} : s[PERF_W-1:0];
    endfunction

    always_comb begin
        late_inc = '0;
        for (int p = 0; p < NUM_LOOKUPS; p++)
            late_inc = late_inc + PERF_W'(lookup_valid[p] & lookup_late_prefetch[p]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            late_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            late_cnt_q  <= sat_add(late_cnt_q, late_inc);
            stall_cnt_q <= sat_add(stall_cnt_q, PERF_W'(allocate_valid && !allocate_ready));
        end
    end

    assign perf_late_pf     = late_cnt_q;
    assign perf_alloc_stall = stall_cnt_q;
`else
    assign perf_late_pf     = '0;
    assign perf_alloc_stall = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_valid) a_fill_pending : assert (st_q[fill_id] == ST_PENDING);
            if (release_valid) a_release_busy : assert (st_q[release_id] != ST_FREE);
            if (alloc_fire) a_alloc_free : assert (st_q[allocate_id] == ST_FREE);
        end
    end
`endif

endmodule

// File: doc/vx_mshr_pf.md
Name: vx_mshr_pf

Overview:
- Next-generation cache-bank miss reservation table (MSHR) with explicit prefetch tracking.
- Holds outstanding line misses, with a per-entry state machine and multiple lookup ports.
- Per lookup port: late-prefetch detection and prefetch-to-demand promotion.
- Fill merges all same-line pending entries; ready entries dequeue in lowest-index priority order.
- Sits between bank tag-check stage (allocate/lookup), memory response path (fill) and bank replay pipeline (dequeue/release).

Parameters:
- MSHR_SIZE, 8, number of entries (power of 2, >=2).
- NUM_LOOKUPS, 2, independent lookup ports.
- LINE_ADDR_WIDTH, 26, line address bits.
- DATA_WIDTH, 32, opaque per-entry request payload bits.
- ID_WIDTH, $clog2(MSHR_SIZE), entry index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- allocate_valid  in  1  allocate request
- allocate_addr  in  LINE_ADDR_WIDTH  missing line
- allocate_data  in  DATA_WIDTH  payload
- allocate_prefetch  in  1  request is a prefetch
- allocate_ready  out  1  free entry available
- allocate_id  out  ID_WIDTH  entry to be written on fire
- lookup_valid  in  NUM_LOOKUPS  per-port lookup strobe
- lookup_addr  in  NUM_LOOKUPS*LINE_ADDR_WIDTH  per-port line address
- lookup_match  out  NUM_LOOKUPS  non-FREE entry with equal address exists
- lookup_late_prefetch  out  NUM_LOOKUPS  matching entry still flagged prefetch
- fill_valid  in  1  memory response arrived
- fill_id  in  ID_WIDTH  entry filled
- fill_addr  out  LINE_ADDR_WIDTH  address of entry fill_id (combinational)
- dequeue_valid  out  1  replay candidate valid
- dequeue_id  out  ID_WIDTH  candidate entry
- dequeue_addr  out  LINE_ADDR_WIDTH  candidate address
- dequeue_data  out  DATA_WIDTH  candidate payload
- dequeue_prefetch  out  1  candidate prefetch flag
- dequeue_ready  in  1  replay pipeline accepts
- release_valid  in  1  free entry
- release_id  in  ID_WIDTH  entry to free
- perf_late_pf  out  32  late-prefetch hit counter
- perf_alloc_stall  out  32  allocate_valid && !allocate_ready cycle counter

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset:
  - all entries FREE, prefetch bits 0.
  - allocate_ready=0, dequeue_valid=0, allocate_id=0, perf counters 0.
  - allocate_ready=1 one cycle after reset deasserts.
  - Reset mid-operation discards everything.
- Entry FSM: FREE -> PENDING (allocate fire) -> READY (fill) -> DRAIN (dequeue fire) -> FREE (release).
  - release is legal from PENDING, READY or DRAIN; the entry returns to FREE.
- allocate_ready/allocate_id:
  - registered, computed from next-state FREE vector (lowest-index FREE).
  - Fire = allocate_valid && allocate_ready; writes addr/data/prefetch into allocate_id.
  - New entry is visible to lookup the next cycle.
  - A release in cycle N makes the entry allocatable in cycle N+1.
- Lookup (combinational, per port):
  - match = OR over non-FREE entries of address equality.
  - late_prefetch = a matching entry has its prefetch bit set.
  - lookup_valid && late_prefetch clears that entry's prefetch bit next cycle (promotion); multiple ports promoting the same entry is legal.
- Fill:
  - entry fill_id -> READY.
  - every other PENDING entry with equal address -> READY in the same cycle (merge).
- Dequeue:
  - dequeue_* registered; lowest-index READY entry, excluding the entry firing this cycle.
  - Fire = dequeue_valid && dequeue_ready -> entry DRAIN.
  - Fill-to-dequeue_valid latency is 1 cycle.
  - dequeue_* hold stable while valid and not ready.
- Simultaneous allocate+release on different ids both apply. Release overrides promotion on the same id.
- Assertions (simulation only):
  - fill on non-PENDING entry;
  - release on FREE entry;
  - allocate fire when allocate_id is not FREE.

Optional Feature:
- VX_MSHR_PERF_EN defined:
  - perf_late_pf increments by the number of ports with lookup_valid && lookup_late_prefetch each cycle.
  - perf_alloc_stall increments once per stalled cycle.
  - Both counters saturate at 2^32-1.
- Not defined: both ports tied to 0; no counter flops.

Decomposition:
- Package vx_mshr_pkg: entry state enum (FREE, PENDING, READY, DRAIN, 2-bit), perf counter width constant.
- Sub-module vx_mshr_pf_sel: parametrised lowest-index priority encoder (valid + index), instantiated twice (free select, ready select).

Test Plan:
- Reset -> allocate_ready=0 during reset, 1 the cycle after; allocate 8 entries back-to-back -> ids 0..7, allocate_ready=0 after 8th fire; perf_alloc_stall counts stalled cycles (perf build).
- Allocate prefetch addr 0x100 as id0; lookup port1 addr 0x100 -> match=1, late_prefetch=1 -> next cycle late_prefetch=0, match=1, perf_late_pf=1.
- Allocate demand 0x200 (id0), 0x200 (id1), 0x300 (id2); fill id0 -> next cycle dequeue id0, then id1 after fire; id2 stays PENDING.
- Hold dequeue_ready=0 for 5 cycles with id3 READY -> dequeue_id=3, addr/data stable; assert ready -> id3 DRAIN, next READY presented.
- Release id2 in same cycle as allocate fire on id5 -> both apply; next allocate_id=2.
- Reset asserted with 4 PENDING entries -> all FREE, dequeue_valid=0, lookup of prior addresses -> match=0.
